// File: rtl/ring_pkg.sv
// Shared ring packet layout and NIC queue entry types.
package ring_pkg;

  localparam int unsigned PKT_W   = 64;
  localparam int unsigned VC_BIT  = 63;
  localparam int unsigned DIR_BIT = 62;
  localparam int unsigned HOP_MSB = 55;
  localparam int unsigned HOP_LSB = 48;
  localparam int unsigned SRC_MSB = 47;
  localparam int unsigned SRC_LSB = 32;
  localparam int unsigned PAY_MSB = 31;
  localparam int unsigned PAY_LSB = 0;

  localparam int unsigned HOP_W  = HOP_MSB - HOP_LSB + 1;
  localparam int unsigned SRC_W  = SRC_MSB - SRC_LSB + 1;
  localparam int unsigned PAY_W  = PAY_MSB - PAY_LSB + 1;
  localparam int unsigned TIME_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic             dir;
    logic [HOP_W-1:0] hop;
    logic [PAY_W-1:0] payload;
  } tx_entry_t;

  typedef struct packed {
    logic              vc;
    logic [SRC_W-1:0]  source;
    logic [PAY_W-1:0]  payload;
    logic [TIME_W-1:0] stamp;
  } rx_entry_t;

  // Thermometer hop code: n hops -> n low-order ones.
  function automatic logic [HOP_W-1:0] hop_therm(input logic [2:0] hops);
    logic [HOP_W-1:0] one;
    one = {{(HOP_W-1){1'b0}}, 1'b1};
    return (one << hops) - one;
  endfunction

endpackage

// File: rtl/ring_pe_nic_if.sv
// Host and router side signals of the ring PE NIC.
interface ring_pe_nic_if;
  import ring_pkg::*;

  logic               polarity;
  logic               tx_valid;
  logic               tx_ready;
  logic               tx_dir;
  logic [2:0]         tx_hops;
  logic [PAY_W-1:0]   tx_payload;
  logic               peri;
  logic               pesi;
  logic [PKT_W-1:0]   pedi;
  logic               peso;
  logic [PKT_W-1:0]   pedo;
  logic               pero;
  logic               rx_valid;
  logic               rx_ready;
  logic               rx_vc;
  logic [SRC_W-1:0]   rx_source;
  logic [PAY_W-1:0]   rx_payload;
  logic [TIME_W-1:0]  rx_time;
  logic [CNT_W-1:0]   tx_count;
  logic [CNT_W-1:0]   rx_count;

  modport master (
    output polarity, tx_valid, tx_dir, tx_hops, tx_payload, peri, peso, pedo, rx_ready,
    input  tx_ready, pesi, pedi, pero, rx_valid, rx_vc, rx_source, rx_payload, rx_time,
           tx_count, rx_count
  );

  modport slave (
    input  polarity, tx_valid, tx_dir, tx_hops, tx_payload, peri, peso, pedo, rx_ready,
    output tx_ready, pesi, pedi, pero, rx_valid, rx_vc, rx_source, rx_payload, rx_time,
           tx_count, rx_count
  );

endinterface

// File: rtl/ring_nic_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two >= 2.
module ring_nic_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  // Extra pointer MSB tells a full queue from an empty one.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wr_en    = push && !full;
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ring_pe_nic.sv
// Ring PE NIC: queues host packets for injection into the router and buffers
// ejected packets, stamped with the local cycle count, for the host.
module ring_pe_nic #(
  parameter logic [15:0] NODE_ID  = 16'd0,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  ring_pe_nic_if.slave bus
);
  import ring_pkg::*;

  tx_entry_t         tx_din, tx_dout;
  logic              tx_full, tx_empty, tx_push, tx_pop, tx_ready_w;
  rx_entry_t         rx_din, rx_dout;
  logic              rx_full, rx_empty, rx_push, rx_pop, pero_w;
  logic [TIME_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [PKT_W-1:0]  pedi_w;
  logic              unused_pedo;

  // Ready flags are forced low while reset is held, not just after it.
  always_comb begin
    tx_ready_w = !tx_full && !reset;
    tx_push    = bus.tx_valid && tx_ready_w;
    tx_din     = {bus.tx_dir, hop_therm(bus.tx_hops), bus.tx_payload};
    tx_pop     = !tx_empty && bus.peri;

    pedi_w = '0;
    if (!tx_empty) begin
      pedi_w[VC_BIT]          = bus.polarity;
      pedi_w[DIR_BIT]         = tx_dout.dir;
      pedi_w[HOP_MSB:HOP_LSB] = tx_dout.hop;
      pedi_w[SRC_MSB:SRC_LSB] = NODE_ID;
      pedi_w[PAY_MSB:PAY_LSB] = tx_dout.payload;
    end

    pero_w  = !rx_full && !reset;
    rx_push = bus.peso && pero_w;
    rx_din  = {bus.pedo[VC_BIT], bus.pedo[SRC_MSB:SRC_LSB], bus.pedo[PAY_MSB:PAY_LSB], cyc_q};
    rx_pop  = !rx_empty && bus.rx_ready;
  end

  assign unused_pedo = ^bus.pedo[DIR_BIT:HOP_LSB];

  ring_nic_fifo #(
    .WIDTH ($bits(tx_entry_t)),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_din),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  ring_nic_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_din),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    cyc_d    = cyc_q + 16'd1;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_pop && (tx_cnt_q != '1)) tx_cnt_d = tx_cnt_q + 16'd1;
    if (rx_push && (rx_cnt_q != '1)) rx_cnt_d = rx_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q    <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      cyc_q    <= cyc_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_comb begin
    bus.tx_ready   = tx_ready_w;
    bus.pesi       = tx_pop;
    bus.pedi       = pedi_w;
    bus.pero       = pero_w;
    bus.rx_valid   = !rx_empty;
    bus.rx_vc      = 1'b0;
    bus.rx_source  = '0;
    bus.rx_payload = '0;
    bus.rx_time    = '0;
    if (!rx_empty) begin
      bus.rx_vc      = rx_dout.vc;
      bus.rx_source  = rx_dout.source;
      bus.rx_payload = rx_dout.payload;
      bus.rx_time    = rx_dout.stamp;
    end
    bus.tx_count = tx_cnt_q;
    bus.rx_count = rx_cnt_q;
  end

endmodule

// File: tb/tb_ring_pe_nic.sv
// Scoreboard bench for ring_pe_nic (NODE_ID = 2, depth 4 both ways).
module tb_ring_pe_nic;
  import ring_pkg::*;

  logic        clk, reset;
  logic        loop, drv_peso;
  logic [63:0] drv_pedo;
  int          errors, checks, tb_cyc, accepted;
  logic [15:0] m_tx_cnt, m_rx_cnt, prev_time, cnt_before;
  logic        seen_wrap;
  logic [63:0] tx_exp_q [$];
  logic [64:0] rx_exp_q [$];
  logic [7:0]  hop_tbl [8];

  ring_pe_nic_if bus ();

  ring_pe_nic #(
    .NODE_ID  (16'd2),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.pedo = loop ? bus.pedi : drv_pedo;
  assign bus.peso = loop ? bus.pesi : drv_peso;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: predict this edge's transfers from the settled inputs, then check counters.
  task automatic step();
    logic [63:0] e;
    logic [63:0] cap_pkt;
    logic [64:0] r;
    #1;
    check_eq("tx_ready", bus.tx_ready, tx_exp_q.size() < 4);
    check_eq("pero", bus.pero, rx_exp_q.size() < 4);
    check_eq("rx_valid", bus.rx_valid, rx_exp_q.size() != 0);
    check_eq("pesi", bus.pesi, (tx_exp_q.size() != 0) && bus.peri);
    cap_pkt = drv_pedo;
    if (bus.pesi && tx_exp_q.size() != 0) begin
      e = tx_exp_q.pop_front();
      e[63] = bus.polarity;
      check_eq("pedi", bus.pedi, e);
      if (loop) cap_pkt = e;
      if (m_tx_cnt != 16'hFFFF) m_tx_cnt++;
    end else if (tx_exp_q.size() == 0) begin
      check_eq("pedi_idle", bus.pedi, 64'h0);
    end
    if (bus.rx_valid && bus.rx_ready && rx_exp_q.size() != 0) begin
      r = rx_exp_q.pop_front();
      check_eq("rx_head", {bus.rx_vc, bus.rx_source, bus.rx_payload, bus.rx_time}, r);
      if (bus.rx_time == 16'h0 && tb_cyc > 65536) seen_wrap = 1'b1;
    end else if (rx_exp_q.size() == 0) begin
      check_eq("rx_idle", {bus.rx_vc, bus.rx_source, bus.rx_payload, bus.rx_time}, 0);
    end
    if (bus.peso && bus.pero) begin
      rx_exp_q.push_back({cap_pkt[63], cap_pkt[47:32], cap_pkt[31:0], tb_cyc[15:0]});
      if (m_rx_cnt != 16'hFFFF) m_rx_cnt++;
    end
    if (bus.tx_valid && bus.tx_ready)
      tx_exp_q.push_back({1'b0, bus.tx_dir, 6'b0, hop_tbl[bus.tx_hops], 16'h0002, bus.tx_payload});
    @(posedge clk);
    if (!reset) tb_cyc++;
    @(negedge clk);
    check_eq("tx_count", bus.tx_count, m_tx_cnt);
    check_eq("rx_count", bus.rx_count, m_rx_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_tx", {bus.pesi, bus.tx_ready, bus.pedi, bus.tx_count}, 0);
    check_eq("rst_rx", {bus.pero, bus.rx_valid, bus.rx_vc, bus.rx_source, bus.rx_payload,
                        bus.rx_time, bus.rx_count}, 0);
    tx_exp_q.delete();
    rx_exp_q.delete();
    m_tx_cnt = '0;
    m_rx_cnt = '0;
    tb_cyc   = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_pedo(input logic vc, input logic [15:0] src, input logic [31:0] pay);
    drv_pedo = 64'h0;
    drv_pedo[63]    = vc;
    drv_pedo[62:48] = 15'h5A5A;
    drv_pedo[47:32] = src;
    drv_pedo[31:0]  = pay;
  endtask

  initial begin
    hop_tbl = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
    errors = 0; checks = 0; tb_cyc = 0; seen_wrap = 1'b0;
    m_tx_cnt = '0; m_rx_cnt = '0;
    reset = 1'b0; loop = 1'b0; drv_peso = 1'b0; drv_pedo = '0;
    bus.polarity = 1'b0; bus.tx_valid = 1'b0; bus.tx_dir = 1'b0; bus.tx_hops = '0;
    bus.tx_payload = '0; bus.peri = 1'b0; bus.rx_ready = 1'b0;
    #2;
    do_reset();

    // Single injection with a known packet image.
    bus.polarity = 1'b1; bus.peri = 1'b1;
    bus.tx_valid = 1'b1; bus.tx_dir = 1'b0; bus.tx_hops = 3'd3; bus.tx_payload = 32'hA5;
    #1;
    check_eq("no_bypass", bus.pesi, 1'b0);
    step();
    bus.tx_valid = 1'b0;
    #1;
    check_eq("inj_pesi", bus.pesi, 1'b1);
    check_eq("inj_pedi", bus.pedi, 64'h8007_0002_0000_00A5);
    step();
    check_eq("inj_count", bus.tx_count, 16'd1);

    // Every hop distance, mixed direction and polarity.
    for (int h = 0; h < 8; h++) begin
      bus.tx_valid = 1'b1; bus.tx_hops = 3'(h); bus.tx_dir = (h % 2) == 1;
      bus.tx_payload = 32'h1000 + 32'(h); bus.polarity = (h % 3) == 0;
      step();
    end
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // TX back-pressure: five writes against a stalled router.
    bus.peri = 1'b0; accepted = 0;
    for (int i = 0; i < 5; i++) begin
      bus.tx_valid = 1'b1; bus.tx_payload = 32'h200 + 32'(i);
      #1;
      if (bus.tx_ready) accepted++;
      step();
    end
    bus.tx_valid = 1'b0;
    check_eq("tx_accepted", accepted, 4);
    #1;
    check_eq("tx_full_ready", bus.tx_ready, 1'b0);
    bus.peri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("drain_pesi", bus.pesi, 1'b1);
      step();
    end
    #1;
    check_eq("drain_done", bus.pesi, 1'b0);
    step();

    // RX back-pressure: five ejections with the host stalled.
    bus.peri = 1'b0; bus.rx_ready = 1'b0; accepted = 0;
    for (int i = 0; i < 5; i++) begin
      drv_peso = 1'b1;
      set_pedo((i % 2) == 1, 16'hB000 + 16'(i), 32'hC000_0000 + 32'(i));
      #1;
      if (bus.pero) accepted++;
      step();
    end
    drv_peso = 1'b0;
    check_eq("rx_accepted", accepted, 4);
    #1;
    check_eq("rx_full_pero", bus.pero, 1'b0);
    bus.rx_ready = 1'b1; prev_time = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i > 0) check_eq("rx_time_incr", bus.rx_time > prev_time, 1'b1);
      prev_time = bus.rx_time;
      step();
    end
    bus.rx_ready = 1'b0;

    // Full RX: pop and refused capture in the same cycle.
    for (int i = 0; i < 4; i++) begin
      drv_peso = 1'b1;
      set_pedo(1'b0, 16'h00D0, 32'hD00 + 32'(i));
      step();
    end
    bus.rx_ready = 1'b1; drv_peso = 1'b1;
    set_pedo(1'b1, 16'hDEAD, 32'hDEAD_BEEF);
    #1;
    check_eq("full_pero", bus.pero, 1'b0);
    cnt_before = m_rx_cnt;
    step();
    check_eq("full_rx_count", bus.rx_count, cnt_before);
    drv_peso = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Reset with traffic queued in both directions.
    bus.rx_ready = 1'b0; bus.peri = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.tx_valid = i < 2; bus.tx_payload = 32'h300 + 32'(i);
      drv_peso = 1'b1;
      set_pedo(1'b0, 16'h0030, 32'h400 + 32'(i));
      step();
    end
    bus.tx_valid = 1'b0; drv_peso = 1'b0;
    #2;
    do_reset();
    bus.peri = 1'b1; bus.rx_ready = 1'b1;
    #1;
    check_eq("stale_after_rst", {bus.pesi, bus.rx_valid}, 2'b00);
    for (int i = 0; i < 4; i++) step();

    // Long loopback run: cycle counter wrap and counter saturation.
    do_reset();
    loop = 1'b1; bus.peri = 1'b1; bus.rx_ready = 1'b1; bus.tx_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      bus.tx_payload = 32'(i); bus.tx_hops = 3'(i % 8);
      bus.tx_dir = (i % 3) == 0; bus.polarity = (i % 5) < 2;
      step();
    end
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("sat_tx", bus.tx_count, 16'hFFFF);
    check_eq("sat_rx", bus.rx_count, 16'hFFFF);
    check_eq("cyc_wrap", seen_wrap, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
